// File: rtl/dummy_pkg.sv
// Shared types for the dummy coprocessor slice: reorder-buffer slot states.
package dummy_pkg;

    // Per-slot lifecycle: FREE -> PENDING (alloc) -> DONE (result) -> FREE (commit)
    typedef enum logic [1:0] {
        ROB_FREE    = 2'd0,
        ROB_PENDING = 2'd1,
        ROB_DONE    = 2'd2
    } rob_state_t;

endpackage : dummy_pkg

// File: rtl/dummy_rob.sv
// In-order result reorder buffer behind the dummy coprocessor.
// Tags are allocated at issue and ride through the coprocessor. Results come
// back out of order into their tagged slot. Commit drains strictly in
// allocation order.
module dummy_rob
    import dummy_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    localparam int TagW       = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    output logic [TagW-1:0]       alloc_tag_o,
    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [TagW-1:0]       res_tag_i,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    output logic                  commit_valid_o,
    input  logic                  commit_ready_i,
    output logic [TagW-1:0]       commit_tag_o,
    output logic [DATA_WIDTH-1:0] commit_data_o,
    output logic [TagW:0]         count_o,
    output logic                  err_o
);

    localparam logic [TagW:0] LP_FULL_CNT = (TagW+1)'(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TagW:0]           r_head;
    logic [TagW:0]           r_tail;
    rob_state_t              r_state [DEPTH];
    logic [DATA_WIDTH-1:0]   r_data  [DEPTH];
    logic                    r_err;

    logic [TagW:0]           w_count;
    logic                    w_full;
    logic [TagW-1:0]         w_head_idx;
    logic [TagW-1:0]         w_tail_idx;
    logic                    w_alloc_fire;
    logic                    w_res_fire;
    logic                    w_res_hit;
    logic                    w_commit_valid;
    logic                    w_commit_fire;

    assign w_count        = r_tail - r_head;
    assign w_full         = (w_count == LP_FULL_CNT);
    assign w_head_idx     = r_head[TagW-1:0];
    assign w_tail_idx     = r_tail[TagW-1:0];

    // Alloc readiness depends on registered occupancy only; a same-cycle
    // commit does not free a slot for a same-cycle alloc.
    assign w_alloc_fire   = alloc_valid_i && !w_full;
    assign w_res_fire     = res_valid_i;
    assign w_res_hit      = (r_state[res_tag_i] == ROB_PENDING);
    assign w_commit_valid = (r_state[w_head_idx] == ROB_DONE);
    assign w_commit_fire  = w_commit_valid && commit_ready_i;

    assign alloc_ready_o  = !w_full;
    assign alloc_tag_o    = w_tail_idx;
    assign res_ready_o    = 1'b1;
    assign commit_valid_o = w_commit_valid;
    assign commit_tag_o   = w_head_idx;
    assign commit_data_o  = r_data[w_head_idx];
    assign count_o        = w_count;
    assign err_o          = r_err;

    // Head/tail pointer advance; flush behaves like reset for the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_alloc_fire)  r_tail <= r_tail + 1'b1;
            if (w_commit_fire) r_head <= r_head + 1'b1;
        end
    end

    // Per-slot state machine. Alloc, result and commit target distinct slots
    // in any legal cycle, so the per-slot updates never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ROB_FREE;
                r_data[i]  <= '0;
            end
        end else if (flush_i) begin
            // Data is left as-is; it is unreachable until rewritten by a result.
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ROB_FREE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (w_tail_idx == TagW'(i))) begin
                    r_state[i] <= ROB_PENDING;
                end
                if (w_res_fire && w_res_hit && (res_tag_i == TagW'(i))) begin
                    r_state[i] <= ROB_DONE;
                    r_data[i]  <= res_data_i;
                end
                if (w_commit_fire && (w_head_idx == TagW'(i))) begin
                    r_state[i] <= ROB_FREE;
                end
            end
        end
    end

    // Error pulse for a result landing on a slot that is not awaiting one
    // (stale tag after flush, or duplicate result).
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_res_fire && !w_res_hit;
        end
    end

endmodule : dummy_rob
